// File: rtl/gray_burst_arbiter_if.sv
// Request/grant bus between the sequencing clients and the Gray burst arbiter.
interface gray_burst_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int CBITS = 10
);
  logic [NREQ-1:0]       req;
  logic [NREQ*CBITS-1:0] len;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [CBITS-1:0]      gray_c;
  logic                  sig;
  logic [NREQ-1:0]       done;

  modport master (
    output req, len,
    input  grant, busy, gray_c, sig, done
  );

  modport slave (
    input  req, len,
    output grant, busy, gray_c, sig, done
  );
endinterface

// File: rtl/gray_burst_arbiter.sv
// Round-robin arbiter sharing one binary step counter among NREQ requesters;
// the owner's burst of len counts is published in Gray code, then done pulses.
module gray_burst_arbiter #(
  parameter int NREQ  = 4,
  parameter int CBITS = 10
) (
  input logic                 clk,
  input logic                 rst,
  gray_burst_arbiter_if.slave bus
);

  localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned N  = NREQ;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    ptr;      // last granted requester; doubles as current owner
  logic [CBITS-1:0] cnt;
  logic [CBITS-1:0] last;     // latched len-1; len==0 wraps to all-ones (full burst)

  logic [PW-1:0]    pick;
  logic             found;
  logic [31:0]      idx;
  logic [CBITS-1:0] len_sel;
  logic [NREQ-1:0]  own_oh;

  // Round-robin scan starting just after the last owner
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && bus.req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  // Burst length of the requester about to be granted
  always_comb begin
    len_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick == PW'(i)) len_sel = bus.len[i*CBITS +: CBITS];
    end
  end

  // Arbitration FSM and shared step counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= '0;
      ptr   <= PW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            ptr   <= pick;
            cnt   <= '0;
            last  <= len_sel - CBITS'(1);
            state <= RUN;
          end
        end
        RUN: begin
          if (!bus.req[ptr])     state <= IDLE;
          else if (cnt == last)  state <= DONE;
          else                   cnt   <= cnt + CBITS'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded from state so reset clears them immediately
  always_comb begin
    own_oh     = NREQ'(1) << ptr;
    bus.busy   = (state == RUN);
    bus.grant  = bus.busy ? own_oh : '0;
    bus.done   = (state == DONE) ? own_oh : '0;
    bus.gray_c = bus.busy ? (cnt ^ (cnt >> 1)) : '0;
    bus.sig    = bus.busy && (cnt == '0);
  end

endmodule
